// File: rtl/cu_pkg.sv
// cu_pkg: instruction field layout, opcodes, pcControl codes and FSM encoding for cu_sequencer.
package cu_pkg;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int IMM_BIT = 26;
  localparam int FLAG_BIT = 25;
  localparam int FLAG1_BIT = 24;
  localparam int OP1_MSB = 23;
  localparam int OP1_LSB = 21;
  localparam int OP2_MSB = 20;
  localparam logic [4:0] OP_MOV = 5'd12;
  localparam logic [4:0] OP_BEQ = 5'd13;
  localparam logic [4:0] OP_BZ = 5'd20;
  localparam logic [4:0] OP_JR = 5'd21;
  localparam logic [4:0] OP_HALT = 5'd22;
  localparam logic [3:0] PC_NONE = 4'd0;
  localparam logic [3:0] PC_JR = 4'd9;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMWAIT, S_HALT, S_ILLEGAL
  } state_t;
  typedef struct packed {
    logic [4:0] alucode;
    logic [3:0] pccontrol;
    logic writecode;
    logic imcontrol;
    logic flag;
    logic flag1;
    logic [2:0] op1;
    logic [20:0] op2;
  } ctrl_t;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode-to-control mapping for one instruction word.
module cu_decode
  import cu_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        halt,
  output logic        bad
);
  logic [4:0] opc;
  assign opc = ir[OP_MSB:OP_LSB];
  always_comb begin
    ctrl = '0;
    ctrl.imcontrol = ir[IMM_BIT];
    ctrl.flag = ir[FLAG_BIT];
    ctrl.flag1 = ir[FLAG1_BIT];
    ctrl.op1 = ir[OP1_MSB:OP1_LSB];
    ctrl.op2 = ir[OP2_MSB:0];
    ctrl.alucode = (opc < OP_MOV) ? opc : 5'd0;
    ctrl.writecode = opc == OP_MOV;
    // Branches map BEQ..BZ onto pcControl 1..8
    ctrl.pccontrol = (opc >= OP_BEQ && opc <= OP_BZ) ? 4'(opc - 5'd12) :
                     (opc == OP_JR) ? PC_JR : PC_NONE;
    halt = opc == OP_HALT;
    bad = opc > OP_HALT;
  end
endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: fetch/decode/execute control FSM driving the datapath controls and retire count.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       pc_in,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [31:0]       instr_data,
  output logic [4:0]        alucode,
  output logic [2:0]        op1,
  output logic [20:0]       op2,
  output logic              imControl,
  output logic              flag,
  output logic              flag1,
  output logic              writecode,
  output logic [3:0]        pcControl,
  output logic              dp_step,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [15:0]       retired
);
  state_t state, nxt;
  ctrl_t ctrl_q, dec;
  logic [31:0] ir;
  logic [1:0] rs;
  logic start_q, dec_halt, dec_bad, unused_pc;
  assign instr_addr = pc_in[ADDR_W-1:0];
  assign unused_pc = ^pc_in[31:ADDR_W];
  assign {alucode, pcControl, writecode, imControl, flag, flag1, op1, op2} = ctrl_q;
  cu_decode u_dec (.ir(ir), .ctrl(dec), .halt(dec_halt), .bad(dec_bad));
  // Reset asserts immediately but the FSM only starts moving once release has passed two flops
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rs <= '0;
    else rs <= {rs[0], 1'b1};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else if (rs[1]) state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:   nxt = instr_valid ? S_DECODE : S_FETCH;
      S_DECODE:  nxt = dec_halt ? S_HALT : dec_bad ? S_ILLEGAL : S_EXEC;
      S_EXEC:    nxt = (ctrl_q.flag | ctrl_q.flag1) ? S_MEMWAIT : S_FETCH;
      S_MEMWAIT: nxt = S_FETCH;
      S_HALT:    nxt = (start && !start_q) ? S_IDLE : S_HALT;
      default:   nxt = state;
    endcase
  end
  always_comb begin
    instr_req = state == S_FETCH;
    dp_step = state == S_EXEC;
    busy = !(state inside {S_IDLE, S_HALT, S_ILLEGAL});
    halted = state == S_HALT;
    illegal = state == S_ILLEGAL;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ir <= '0;
      ctrl_q <= '0;
      retired <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      if (state == S_FETCH && instr_valid) ir <= instr_data;
      if (state == S_DECODE && !dec_halt && !dec_bad) ctrl_q <= dec;
      if (state == S_EXEC) retired <= retired + 16'd1;
    end
endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: directed-vector self-checking bench for cu_sequencer.
module tb_cu_sequencer;
  logic clock = 0, reset_n, start, instr_valid;
  logic [31:0] pc_in, instr_data;
  logic instr_req, imControl, flag, flag1, writecode, dp_step, busy, halted, illegal;
  logic [9:0] instr_addr;
  logic [4:0] alucode;
  logic [2:0] op1;
  logic [20:0] op2;
  logic [3:0] pcControl;
  logic [15:0] retired;
  int n_tests = 0, n_fail = 0;

  cu_sequencer #(.ADDR_W(10)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pc_in(pc_in),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_data(instr_data), .alucode(alucode), .op1(op1), .op2(op2),
    .imControl(imControl), .flag(flag), .flag1(flag1), .writecode(writecode),
    .pcControl(pcControl), .dp_step(dp_step), .busy(busy), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] iw(input logic [4:0] opc, input logic imm, input logic f,
                                     input logic f1, input logic [2:0] o1, input logic [20:0] o2);
    return {opc, imm, f, f1, o1, o2};
  endfunction

  initial begin
    reset_n = 0; start = 0; instr_valid = 0; instr_data = 0; pc_in = 32'h1234_5677;
    tick(2);
    check("rst_req", instr_req, 0);
    check("rst_busy", busy, 0);
    check("rst_step", dp_step, 0);
    check("rst_ctrl", {alucode, pcControl, writecode, op1, op2}, 0);
    check("rst_ret", retired, 0);
    reset_n = 1;
    tick(3);
    // ADD, zero-wait fetch
    start = 1; instr_valid = 1; instr_data = iw(5'd1, 1, 0, 0, 3'd2, 21'd5);
    tick();
    check("add_req", instr_req, 1);
    check("add_busy", busy, 1);
    check("add_addr", instr_addr, 10'h277);
    tick();
    check("add_dec_req", instr_req, 0);
    check("add_dec_step", dp_step, 0);
    tick();
    check("add_step", dp_step, 1);
    check("add_alu", alucode, 1);
    check("add_op1", op1, 2);
    check("add_op2", op2, 5);
    check("add_imm", imControl, 1);
    check("add_pc", pcControl, 0);
    tick();
    check("add_step_off", dp_step, 0);
    check("add_ret", retired, 1);
    check("add_next_req", instr_req, 1);
    // BEQ with memory operand
    instr_data = iw(5'd13, 0, 1, 0, 3'd0, 21'h1ABCD);
    tick(2);
    check("beq_step", dp_step, 1);
    check("beq_pc", pcControl, 1);
    check("beq_alu", alucode, 0);
    check("beq_flag", flag, 1);
    check("beq_op2", op2, 21'h1ABCD);
    tick();
    check("beq_mw_step", dp_step, 0);
    check("beq_mw_req", instr_req, 0);
    check("beq_mw_busy", busy, 1);
    tick();
    check("beq_next_req", instr_req, 1);
    check("beq_ret", retired, 2);
    // MOV with fetch delayed 5 cycles, start dropped mid-instruction
    instr_valid = 0; start = 0; instr_data = iw(5'd12, 0, 0, 0, 3'd5, 21'd7);
    for (int i = 0; i < 6; i++) begin
      check("dly_req", instr_req, 1);
      check("dly_addr", instr_addr, 10'h277);
      if (i == 5) instr_valid = 1;
      tick();
    end
    check("dly_dec_req", instr_req, 0);
    tick();
    check("mov_step", dp_step, 1);
    check("mov_wr", writecode, 1);
    check("mov_alu", alucode, 0);
    check("mov_op1", op1, 5);
    tick();
    check("mov_cont_req", instr_req, 1);
    check("mov_ret", retired, 3);
    // JR
    instr_data = iw(5'd21, 0, 0, 0, 3'd0, 21'd0);
    tick(2);
    check("jr_pc", pcControl, 9);
    check("jr_wr", writecode, 0);
    tick();
    check("jr_ret", retired, 4);
    // HALT
    instr_data = iw(5'd22, 0, 0, 0, 3'd0, 21'd0);
    tick(2);
    check("hlt_halted", halted, 1);
    check("hlt_busy", busy, 0);
    check("hlt_step", dp_step, 0);
    check("hlt_pc_held", pcControl, 9);
    tick(2);
    check("hlt_stay", halted, 1);
    check("hlt_ret", retired, 4);
    start = 1;
    tick();
    check("hlt_idle_halted", halted, 0);
    check("hlt_idle_busy", busy, 0);
    check("hlt_idle_req", instr_req, 0);
    tick();
    check("hlt_refetch", instr_req, 1);
    // ILLEGAL
    instr_data = iw(5'd25, 0, 0, 0, 3'd0, 21'd0);
    tick(2);
    check("ill_flag", illegal, 1);
    check("ill_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      start = i[0];
      tick();
      check("ill_stay", illegal, 1);
      check("ill_step", dp_step, 0);
    end
    #2 reset_n = 0;
    #1;
    check("ill_rst", illegal, 0);
    check("ill_rst_ret", retired, 0);
    check("ill_rst_ctrl", pcControl, 0);
    start = 0;
    tick();
    reset_n = 1;
    tick(3);
    // Retire counter wrap: jump the count near its limit instead of running 65k NOPs
    force dut.retired = 16'hFFFE;
    #1 release dut.retired;
    start = 1; instr_data = 32'd0;
    tick(3);
    check("nop_step", dp_step, 1);
    tick();
    check("wrap_ffff", retired, 16'hFFFF);
    tick(3);
    check("wrap_zero", retired, 0);
    tick(2);
    check("rst_exec_step_before", dp_step, 1);
    #2 reset_n = 0;
    #1;
    check("rst_exec_step", dp_step, 0);
    check("rst_exec_ret", retired, 0);
    check("rst_exec_busy", busy, 0);
    // Release synchronisation: no state change before the second edge
    tick();
    reset_n = 1;
    tick();
    check("sync_e1", instr_req, 0);
    tick();
    check("sync_e2", instr_req, 0);
    tick();
    check("sync_e3", instr_req, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-address width, matching the datapath RAM address width.
REQ-002 clock  input  1  processor clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; leaves IDLE when sampled high.
REQ-005 pc_in  input  32  current datapath PC.
REQ-006 instr_req  output  1  fetch request, held until instr_valid.
REQ-007 instr_addr  output  ADDR_W  fetch address, equal to pc_in[ADDR_W-1:0].
REQ-008 instr_valid  input  1  instruction-memory data valid.
REQ-009 instr_data  input  32  instruction word.
REQ-010 alucode  output  5; op1  output  3; op2  output  21; imControl, flag, flag1, writecode  output  1 each; pcControl  output  4: registered datapath controls.
REQ-011 dp_step  output  1  one-cycle datapath execute strobe.
REQ-012 busy, halted, illegal  output  1 each  status; retired  output  16  retired-instruction count.

Function
REQ-013 Instruction word fields SHALL be: [31:27] opcode, [26] imControl, [25] flag, [24] flag1, [23:21] op1, [20:0] op2.
REQ-014 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEMWAIT, HALT, ILLEGAL.
REQ-015 IDLE->FETCH when start=1; busy=1 in every state except IDLE, HALT and ILLEGAL.
REQ-016 FETCH asserts instr_req and moves to DECODE on the cycle instr_valid=1, latching instr_data; there is no timeout.
REQ-017 DECODE (1 cycle) SHALL drive registered controls per REQ-018..022, then go to EXEC, or to HALT/ILLEGAL.
REQ-018 Opcodes 0-11: alucode=opcode, pcControl=0, writecode=0.
REQ-019 Opcode 12 (MOV): alucode=0, pcControl=0, writecode=1.
REQ-020 Opcodes 13-20 (BEQ, BLT, BGT, BNE, BLE, BGE, BNZ, BZ): alucode=0, writecode=0, pcControl=opcode-12.
REQ-021 Opcode 21 (JR): pcControl=9, alucode=0, writecode=0; opcode 22: HALT; opcodes 23-31: ILLEGAL.
REQ-022 Field bits imControl/flag/flag1/op1/op2 SHALL be copied unmodified for opcodes 0-21.
REQ-023 EXEC SHALL assert dp_step for exactly one cycle; next state MEMWAIT if flag|flag1, else FETCH.
REQ-024 MEMWAIT SHALL last exactly one cycle with dp_step=0, then FETCH.
REQ-025 retired SHALL increment by 1 in EXEC and wrap from 16'hFFFF to 0.
REQ-026 Base latency: 3 cycles per instruction with zero-wait fetch, 4 with memory operand.
REQ-027 HALT: halted=1, controls held, dp_step=0; exits only to IDLE when start is low then high again (rising edge).
REQ-028 ILLEGAL: illegal=1, dp_step=0; exits only by reset.
REQ-029 start dropping mid-instruction SHALL NOT abort; the instruction completes and the FSM continues fetching.
REQ-030 instr_valid outside FETCH SHALL be ignored.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, all control outputs 0, dp_step=0, instr_req=0, busy=halted=illegal=0, retired=0.
REQ-032 Reset asserted mid-EXEC SHALL drop dp_step in the same cycle, no retired increment.
REQ-033 Release is synchronised; first state change occurs no earlier than the second posedge after deassertion.

Structure
REQ-034 Opcode constants, field bit positions, pcControl codes and the state encoding SHALL live in shared package cu_pkg.
REQ-035 Opcode-to-control mapping SHALL be one combinational sub-module cu_decode; the FSM, counter and registers stay in cu_sequencer.

Verification
REQ-036 Reset, start=1, instr_data=opcode 1 (ADD), imm=1, op1=2, op2=5, instr_valid zero-wait -> dp_step pulses on cycle 3, alucode=1, op2=5, retired=1.
REQ-037 Opcode 13 (BEQ) with flag=1 -> pcControl=1, dp_step once, MEMWAIT one cycle, next instr_req 4 cycles after prior.
REQ-038 instr_valid delayed 5 cycles -> instr_req held 6 cycles, instr_addr stable = pc_in[9:0].
REQ-039 Opcode 22 -> halted=1, busy=0, no dp_step; start low then high -> IDLE then FETCH.
REQ-040 Opcode 25 -> illegal=1, start toggling has no effect; reset_n low clears it.
REQ-041 Preload retired=16'hFFFF via 65535 NOPs (opcode 0), one more -> retired=0; reset_n low during EXEC -> dp_step drops same cycle.
